// File: rtl/tron_pkg.sv
// Shared types and constants for the trail-grid write arbiter.
package tron_pkg;

    localparam int GRID_W_DEF = 640;
    localparam int GRID_H_DEF = 480;
    localparam int GRID_CELLS = GRID_W_DEF * GRID_H_DEF;
    localparam int ADDR_W     = 19;
    localparam int COORD_W    = 10;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    typedef enum logic {
        PLAYER_1 = 1'b0,
        PLAYER_2 = 1'b1
    } player_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    // Linear cell address, evaluated at full address width so nothing is lost.
    function automatic addr_t cell_addr(input coord_t x, input coord_t y, input addr_t w);
        return addr_t'(y) * w + addr_t'(x);
    endfunction

endpackage

// File: rtl/grid_write_arbiter_if.sv
// Player request / clear / grid-memory write-port bundle.
interface grid_write_arbiter_if;
    import tron_pkg::*;

    logic   p1_req;
    coord_t p1_x;
    coord_t p1_y;
    logic   p1_ack;

    logic   p2_req;
    coord_t p2_x;
    coord_t p2_y;
    logic   p2_ack;

    logic   clear_req;
    logic   clear_busy;
    logic   clear_done;
    logic   oob;

    logic   mem_en;
    logic   mem_we;
    addr_t  mem_addr;
    logic   mem_din;

    modport master (
        output p1_req, p1_x, p1_y, p2_req, p2_x, p2_y, clear_req,
        input  p1_ack, p2_ack, clear_busy, clear_done, oob,
               mem_en, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  p1_req, p1_x, p1_y, p2_req, p2_x, p2_y, clear_req,
        output p1_ack, p2_ack, clear_busy, clear_done, oob,
               mem_en, mem_we, mem_addr, mem_din
    );

endinterface

// File: rtl/grid_clear_seq.sv
// Wipe address sequencer: issues 0..CELLS-1, one address per cycle.
// o_busy is high in every cycle an address is issued (including the start
// cycle, which issues address 0); o_done flags the cycle the last one goes out.
module grid_clear_seq
    import tron_pkg::*;
#(
    parameter int CELLS = GRID_CELLS
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  i_start,
    output logic  o_busy,
    output addr_t o_addr,
    output logic  o_done
);

    localparam addr_t LAST = addr_t'(CELLS - 1);

    logic  r_run;
    addr_t r_cnt;

    assign o_busy = r_run || i_start;
    assign o_addr = r_run ? r_cnt : '0;
    assign o_done = o_busy && (o_addr == LAST);

    // Advance the counter on every issued address; stop after the last one.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (o_busy) begin
            if (o_done) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_run <= 1'b1;
                r_cnt <= o_addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/grid_write_arbiter.sv
// Two-player trail-write arbiter with optional full-grid wipe.
// Build option: define GRID_CLEAR_EN to include the clear engine and CLEAR
// state; without it clear_req is ignored and the FSM never leaves IDLE.
//
// state | meaning
// IDLE  | arbitrate player writes round-robin, accept clear_req
// CLEAR | write 0 to every cell in ascending order, players held off
module grid_write_arbiter
    import tron_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
) (
    input logic                  clock,
    input logic                  reset,
    grid_write_arbiter_if.slave  bus
);

    localparam int          CELLS = GRID_W * GRID_H;
    localparam addr_t       W_A   = addr_t'(GRID_W);
    localparam logic [10:0] X_LIM = 11'(GRID_W);
    localparam logic [10:0] Y_LIM = 11'(GRID_H);

    arb_state_e r_state;
    player_e    r_last_grant;
    logic       r_wipe_tail;

    logic  r_p1_ack;
    logic  r_p2_ack;
    logic  r_oob;
    logic  r_mem_en;
    logic  r_mem_we;
    addr_t r_mem_addr;
    logic  r_mem_din;
    logic  r_clear_busy;
    logic  r_clear_done;

    logic   w_elig1;
    logic   w_elig2;
    logic   w_grant;
    logic   w_pick_p1;
    coord_t w_x;
    coord_t w_y;
    logic   w_oob;
    addr_t  w_addr;

    logic  w_clear_start;
    logic  w_seq_busy;
    addr_t w_seq_addr;
    logic  w_seq_done;

`ifdef GRID_CLEAR_EN
    assign w_clear_start = bus.clear_req && (r_state == ST_IDLE);

    grid_clear_seq #(
        .CELLS (CELLS)
    ) u_clear_seq (
        .clock   (clock),
        .reset   (reset),
        .i_start (w_clear_start),
        .o_busy  (w_seq_busy),
        .o_addr  (w_seq_addr),
        .o_done  (w_seq_done)
    );
`else
    assign w_clear_start = 1'b0;
    assign w_seq_busy    = 1'b0;
    assign w_seq_addr    = '0;
    assign w_seq_done    = 1'b0;
`endif

    // Pick the requester; a player whose ack is showing this cycle is still
    // holding the request it was just granted, so it is not eligible.
    always_comb begin
        w_elig1   = bus.p1_req && !r_p1_ack;
        w_elig2   = bus.p2_req && !r_p2_ack;
        w_grant   = w_elig1 || w_elig2;
        w_pick_p1 = w_elig1 && (!w_elig2 || (r_last_grant == PLAYER_2));
        w_x       = w_pick_p1 ? bus.p1_x : bus.p2_x;
        w_y       = w_pick_p1 ? bus.p1_y : bus.p2_y;
        w_oob     = ({1'b0, w_x} >= X_LIM) || ({1'b0, w_y} >= Y_LIM);
        w_addr    = cell_addr(w_x, w_y, W_A);
    end

    // FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= PLAYER_2;
            r_wipe_tail  <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p2_ack     <= 1'b0;
            r_oob        <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= 1'b0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_p1_ack     <= 1'b0;
            r_p2_ack     <= 1'b0;
            r_oob        <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_din    <= 1'b0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
            r_wipe_tail  <= w_seq_done;

            case (r_state)
                ST_IDLE: begin
                    if (w_clear_start) begin
                        r_state      <= ST_CLEAR;
                        r_mem_en     <= 1'b1;
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= w_seq_addr;
                        r_clear_busy <= 1'b1;
                    end else if (w_grant) begin
                        r_last_grant <= w_pick_p1 ? PLAYER_1 : PLAYER_2;
                        r_p1_ack     <= w_pick_p1;
                        r_p2_ack     <= !w_pick_p1;
                        if (w_oob) begin
                            r_oob <= 1'b1;
                        end else begin
                            r_mem_en   <= 1'b1;
                            r_mem_we   <= 1'b1;
                            r_mem_din  <= 1'b1;
                            r_mem_addr <= w_addr;
                        end
                    end
                end

                ST_CLEAR: begin
                    if (r_wipe_tail) begin
                        r_state      <= ST_IDLE;
                        r_clear_done <= 1'b1;
                    end else begin
                        r_mem_en     <= 1'b1;
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= w_seq_addr;
                        r_clear_busy <= w_seq_busy;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.p1_ack     = r_p1_ack;
    assign bus.p2_ack     = r_p2_ack;
    assign bus.oob        = r_oob;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
    assign bus.clear_busy = r_clear_busy;
    assign bus.clear_done = r_clear_done;

endmodule
